// File: rtl/serial_adder_n_if.sv
// Operand/result bundle for the digit-serial adder, with a start/busy/done handshake.
// The controller drives the master side and the adder sits on the slave side.
interface serial_adder_n_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, cin, a, b,
        input  busy, done, s, cout, ovf
    );

    modport slave (
        input  start, sub, cin, a, b,
        output busy, done, s, cout, ovf
    );
endinterface

// File: rtl/serial_adder_n.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB digit first, linked by a carry flop.
// Subtraction runs as a + ~b + 1, so a final carry of 1 means no borrow.
module serial_adder_n #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    serial_adder_n_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, RUN} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] opA_q, opA_d;
    logic [WIDTH-1:0] opB_q, opB_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [DIGIT-1:0] sumDigit;
    logic             digitCout;
    logic             msbCarryIn;

    // Ripple chain over the current low digit; the carry into its top cell is kept for overflow.
    always_comb begin
        logic c;
        c          = carry_q;
        sumDigit   = '0;
        msbCarryIn = 1'b0;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) begin
                msbCarryIn = c;
            end
            sumDigit[i] = opA_q[i] ^ opB_q[i] ^ c;
            c = (opA_q[i] & opB_q[i]) | (c & (opA_q[i] ^ opB_q[i]));
        end
        digitCout = c;
    end

    always_comb begin
        state_d = state_q;
        opA_d   = opA_q;
        opB_d   = opB_q;
        acc_d   = acc_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    opA_d   = bus.a;
                    opB_d   = bus.b ^ {WIDTH{bus.sub}};
                    carry_d = bus.sub ? 1'b1 : bus.cin;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Operands shift down so the active digit is always at bit 0; sums enter from the top.
                opA_d   = opA_q >> DIGIT;
                opB_d   = opB_q >> DIGIT;
                acc_d   = (acc_q >> DIGIT) | (WIDTH'(sumDigit) << (WIDTH - DIGIT));
                carry_d = digitCout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    s_d     = acc_d;
                    cout_d  = digitCout;
                    ovf_d   = digitCout ^ msbCarryIn;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            opA_q   <= '0;
            opB_q   <= '0;
            acc_q   <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opA_q   <= opA_d;
            opB_q   <= opB_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = done_q;
    assign bus.s    = s_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_adder_n.sv
// Bench for serial_adder_n: five instances (DIGIT 1,2,4,8,16) share one stimulus stream,
// each tracked cycle by cycle by a reference model; directed vectors target the DIGIT=4 instance.
module tb_serial_adder_n;
    localparam int MAINIDX = 2;
    localparam int NVEC    = 8;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        v;
    } res_t;

    typedef struct {
        logic        sub;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        cout;
        logic        ovf;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sub;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;
    logic        checkEn;

    logic [4:0]  busyV;
    logic [4:0]  doneV;
    logic [4:0]  coutV;
    logic [4:0]  ovfV;
    logic [15:0] sV [5];

    int checkCount = 0;
    int passCount  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic written from signs and a 17-bit sum rather than a carry chain.
    function automatic res_t golden(input logic [15:0] fa, input logic [15:0] fb,
                                    input logic fcin, input logic fsub);
        logic [16:0] t;
        res_t        r;
        if (fsub) begin
            t   = {1'b0, fa} - {1'b0, fb};
            r.s = t[15:0];
            r.c = ~t[16];
            r.v = (fa[15] != fb[15]) && (r.s[15] != fa[15]);
        end else begin
            t   = {1'b0, fa} + {1'b0, fb} + {16'd0, fcin};
            r.s = t[15:0];
            r.c = t[16];
            r.v = (fa[15] == fb[15]) && (r.s[15] != fa[15]);
        end
        return r;
    endfunction

    function automatic logic [15:0] pickOperand();
        logic [15:0] edges [4];
        edges[0] = 16'h0000;
        edges[1] = 16'hFFFF;
        edges[2] = 16'h7FFF;
        edges[3] = 16'h8000;
        if ($urandom_range(0, 7) == 0) return edges[$urandom_range(0, 3)];
        return 16'($urandom());
    endfunction

    for (genvar g = 0; g < 5; g++) begin : gen
        localparam int DIG = 1 << g;
        localparam int NST = 16 / DIG;

        serial_adder_n_if #(.WIDTH(16)) busIf ();

        assign busIf.start = start;
        assign busIf.sub   = sub;
        assign busIf.cin   = cin;
        assign busIf.a     = a;
        assign busIf.b     = b;

        serial_adder_n #(.WIDTH(16), .DIGIT(DIG)) dut (
            .clk_i (clk),
            .rst_i (rst),
            .bus   (busIf)
        );

        assign busyV[g] = busIf.busy;
        assign doneV[g] = busIf.done;
        assign sV[g]    = busIf.s;
        assign coutV[g] = busIf.cout;
        assign ovfV[g]  = busIf.ovf;

        res_t scoreQ [$];
        res_t held;
        int   rem     = 0;
        logic expDone = 1'b0;

        // Cycle model: accept when idle, count N run edges, then retire the queued result.
        always @(posedge clk) begin
            if (rst) begin
                scoreQ.delete();
                rem     = 0;
                expDone = 1'b0;
                held    = '{16'h0000, 1'b0, 1'b0};
            end else begin
                expDone = 1'b0;
                if (rem == 0) begin
                    if (start) begin
                        scoreQ.push_back(golden(a, b, cin, sub));
                        rem = NST;
                    end
                end else begin
                    rem--;
                    if (rem == 0 && scoreQ.size() > 0) begin
                        held    = scoreQ.pop_front();
                        expDone = 1'b1;
                    end
                end
            end
        end

        always @(negedge clk) begin
            if (checkEn) begin
                checkOutput($sformatf("proto_digit%0d", DIG),
                            {13'd0, busyV[g], doneV[g], sV[g], coutV[g], ovfV[g]},
                            {13'd0, rem != 0, expDone, held.s, held.c, held.v});
            end
        end
    end

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        sub   = v.sub;
        a     = v.a;
        b     = v.b;
        cin   = v.cin;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = 16'($urandom());
        b     = 16'($urandom());
        cin   = 1'($urandom());
        sub   = 1'($urandom());
        checkOutput("busy_after_start", {31'd0, busyV[MAINIDX]}, 32'd1);
    endtask

    task automatic waitMainDone(input int budget, output int lat);
        lat = 0;
        while (lat < budget) begin
            @(negedge clk);
            lat++;
            if (doneV[MAINIDX]) return;
        end
        lat = -1;
    endtask

    task automatic checkMainResult(input string name, input logic [15:0] es,
                                   input logic ec, input logic ev);
        checkOutput(name, {14'd0, sV[MAINIDX], coutV[MAINIDX], ovfV[MAINIDX]},
                    {14'd0, es, ec, ev});
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs [NVEC];
        int   lat;
        int   doneSeen;

        vecs[0] = '{1'b0, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0};

        checkEn = 1'b0;
        rst     = 1'b1;
        start   = 1'b0;
        sub     = 1'b0;
        cin     = 1'b0;
        a       = 16'h0000;
        b       = 16'h0000;
        repeat (3) @(negedge clk);
        checkOutput("reset_state",
                    {13'd0, busyV[MAINIDX], doneV[MAINIDX], sV[MAINIDX], coutV[MAINIDX], ovfV[MAINIDX]},
                    32'd0);
        checkEn = 1'b1;
        rst     = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            waitMainDone(12, lat);
            checkOutput($sformatf("latency_vec%0d", i), lat, 32'd4);
            checkMainResult($sformatf("result_vec%0d", i), vecs[i].s, vecs[i].cout, vecs[i].ovf);
        end

        // A second start while busy must not disturb the operation in flight.
        applyStimulus(vecs[0]);
        @(negedge clk);
        sub   = 1'b0;
        a     = 16'hAAAA;
        b     = 16'h5555;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitMainDone(10, lat);
        checkOutput("ignore_latency", lat, 32'd2);
        checkMainResult("ignore_result", 16'h2345, 1'b0, 1'b0);

        // start held high: the next operand set is taken in the done cycle.
        @(negedge clk);
        sub   = 1'b0;
        cin   = 1'b0;
        a     = 16'h1234;
        b     = 16'h1111;
        start = 1'b1;
        waitMainDone(12, lat);
        checkOutput("held_first_latency", lat, 32'd5);
        checkMainResult("held_first_result", 16'h2345, 1'b0, 1'b0);
        a = 16'h7FFF;
        b = 16'h0001;
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b_busy", {31'd0, busyV[MAINIDX]}, 32'd1);
        waitMainDone(12, lat);
        checkOutput("b2b_latency", lat, 32'd4);
        checkMainResult("b2b_result", 16'h8000, 1'b0, 1'b1);

        // Reset two cycles into an operation aborts it and clears the held result.
        applyStimulus(vecs[0]);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_clear",
                    {13'd0, busyV[MAINIDX], doneV[MAINIDX], sV[MAINIDX], coutV[MAINIDX], ovfV[MAINIDX]},
                    32'd0);
        doneSeen = 0;
        repeat (8) begin
            @(negedge clk);
            if (doneV[MAINIDX]) doneSeen++;
        end
        checkOutput("abort_no_done", doneSeen, 32'd0);

        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        sub   = 1'b0;
        a     = 16'h1234;
        b     = 16'h1111;
        @(negedge clk);
        checkOutput("rst_wins_busy", {31'd0, busyV[MAINIDX]}, 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        doneSeen = 0;
        repeat (6) begin
            @(negedge clk);
            if (doneV[MAINIDX]) doneSeen++;
        end
        checkOutput("rst_wins_no_done", doneSeen, 32'd0);

        // Random sweep: every instance is checked each cycle against its own model.
        for (int c = 0; c < 18000; c++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) != 0);
            a     = pickOperand();
            b     = pickOperand();
            cin   = 1'($urandom());
            sub   = 1'($urandom());
        end
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
